bram_rd_stream: RTL and testbench
=================================

# bram_rd_stream

Read-side companion of the receive-path ping-pong BRAM capture controller. Once the capture controller flags a finished frame (two full banks, or a short frame cut by `sinc`), this block reads the captured samples out of bank A then bank B. It streams them on an AXI4-Stream master toward the DMA/host path. It also drives the `rdy_w` busy vector that the capture controller checks before starting a new frame, so a bank is never overwritten before it has been drained.

## Interface
Parameters:
- `DEPTH`, 2048, words per bank.
- `DATA_W`, 32, sample width.
- `ADDR_W`, 32, BRAM byte-address width; address = word index × 4.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Asynchronous and active-high.
- `rdy`  in  3  capture status from the capture controller: `3'b011` = full or ended-in-bank-B frame; `3'b101` = frame ended in bank A; other values = no complete frame.
- `size_data`  in  32  total captured words, valid while `rdy` shows a complete frame.
- `rd_busy`  out  2  to the capture controller's `rdy_w`: bit0 = bank A not yet drained, bit1 = bank B not yet drained.
- `bram_addr`  out  ADDR_W  shared read byte address for both banks.
- `en_a_rd`, `en_b_rd`  out  1  read enables for bank A and bank B.
- `dout_a`, `dout_b`  in  DATA_W  bank read data, valid 1 cycle after the enable.
- `m_axis_tdata`  out  DATA_W  stream data.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tready`  in  1  stream ready.
- `m_axis_tlast`  out  1  marks the final beat of the frame.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- Complete frame: `cmp(r) = (r==3'b011)||(r==3'b101)`.
- `rdy_q` registers `rdy`. Trigger condition: `cmp(rdy) && !cmp(rdy_q)`.
- States: IDLE, HDR (only with the macro), READ, DRAIN, DONE.
- IDLE, on trigger:
  - Latch `N = min(size_data, 2*DEPTH)`, using 32-bit unsigned compare.
  - Set `rd_busy = {N>DEPTH, N!=0}`.
  - If `N==0`, go to DONE. Otherwise go to HDR or READ.
- READ:
  - Word index `w` runs 0..N-1.
  - `w<DEPTH`: read bank A at `w*4`. Otherwise read bank B at `(w-DEPTH)*4`.
  - A read is issued only if the output buffer has space after accounting for in-flight reads. Use a 2-entry skid/output buffer; no beat is lost or duplicated under backpressure.
  - After issuing `w==N-1`, go to DRAIN.
- DRAIN: wait until every buffered beat has been accepted, then go to DONE.
- `m_axis_tlast` = 1 only on beat N-1.
- `rd_busy` updates, each on the accepting handshake (`tvalid && tready`):
  - bit0 clears on acceptance of word `min(N,DEPTH)-1`.
  - bit1 clears on acceptance of word N-1.
- DONE: pulse `done` for 1 cycle with `rd_busy==2'b00`, then go to IDLE.
- Changes on `rdy`/`size_data` outside IDLE are ignored. The edge register still tracks them, so a frame that completes mid-read is not replayed.
- While `tvalid && !tready`: `tdata`/`tlast` hold stable and `tvalid` stays high.

## Timing
- Reset values:
  - `rd_busy=0`, `bram_addr=0`, `en_a_rd=0`, `en_b_rd=0`, `m_axis_tdata=0`, `m_axis_tvalid=0`, `m_axis_tlast=0`, `done=0`.
  - State = IDLE.
  - `rdy_q=3'b011`, so a complete `rdy` already held at reset release does not retrigger.
- Reset mid-frame: all outputs return to their reset values asynchronously, and the frame is abandoned.
- Trigger sampled at edge k:
  - `rd_busy` valid after edge k.
  - First enable is asserted in cycle k+1.
  - First `tvalid` appears after edge k+2 (without the macro).
- Throughput: 1 beat/cycle while `m_axis_tready` is held high.
- `done` rises on the edge after the final beat is accepted.

## Configuration
- `BRAM_RD_HEADER_EN` defined:
  - HDR state emits one beat before the data, with `tvalid` after edge k+1.
  - Header = `{rdy_latched[2:0], 16'b0, N[12:0]}`, with `tlast=0`.
  - Data beats then follow as normal.
- Not defined: HDR state is absent, and only the N data beats are emitted.

## Test plan
- `rdy` 000→011, `size_data=4096`, `tready=1`, banks preloaded A[i]=i, B[i]=0x1000+i:
  - 4096 beats: 0..2047 then 0x1000..0x17FF.
  - `tlast` only on beat 4095.
  - `rd_busy` 11→10 after beat 2047, 10→00 after beat 4095.
  - `done` pulses once.
- `rdy`=101, `size_data=5`: beats A[0..4], `tlast` on the 5th, `rd_busy` 01→00, bank B never enabled.
- `size_data=8`, `tready` pattern 1,0,1,0…: exactly 8 beats, in order; `tdata` stable across every stalled cycle.
- `size_data=0`: no `tvalid`, `done` 1 cycle after trigger. `size_data=5000`: clamped to 4096 beats.
- `rst` pulsed at beat 100 with `rdy=011` held: outputs go to reset values immediately, and no restart after release. A later 000→011 transition reads the full frame.
- `BRAM_RD_HEADER_EN`, `rdy=011`, `size_data=3000`: first beat `0x60000BB8`, then 3000 data beats with `tlast` on the last one.

Source files
------------

// File: rtl/bram_rd_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_rd_stream_if
// Brief    : AXI4-Stream data/valid/ready/last bundle for the BRAM read stream.
// Revision : 1.0 - initial release
// ============================================================================
interface bram_rd_stream_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/bram_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : bram_rd_stream
// Brief    : Drains a captured ping-pong frame (bank A then bank B) onto an
//            AXI4-Stream master. Define BRAM_RD_HEADER_EN to prepend a header.
// Revision : 1.0 - initial release
// ============================================================================
module bram_rd_stream #(
    parameter int DEPTH  = 2048,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        rdy,
    input  logic [31:0]       size_data,
    output logic [1:0]        rd_busy,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              en_a_rd,
    output logic              en_b_rd,
    input  logic [DATA_W-1:0] dout_a,
    input  logic [DATA_W-1:0] dout_b,
    bram_rd_stream_if.master  m_axis,
    output logic              done
);

    localparam logic [31:0] c_DEPTH = 32'(DEPTH);
    localparam logic [31:0] c_MAX   = 32'(2 * DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3
`ifdef BRAM_RD_HEADER_EN
        ,ST_HDR  = 3'd4
`endif
    } state_t;

    function automatic logic f_cmp(input logic [2:0] r);
        return (r == 3'b011) || (r == 3'b101);
    endfunction

    state_t            r_state, w_next;
    logic [2:0]        r_rdy_q;
    logic [31:0]       r_n, r_lasta, r_w;
    logic              r_infl, r_infl_b, r_infl_last, r_infl_lasta;
    logic [DATA_W-1:0] r_d0, r_d1;
    logic              r_l0, r_l1, r_a0, r_a1;
    logic [1:0]        r_cnt;
`ifdef BRAM_RD_HEADER_EN
    logic [2:0]        r_rdy_lat;
`endif

    logic              w_trig, w_pop, w_push, w_issue, w_hdr_push, w_bank, w_space;
    logic              w_plast, w_plasta;
    logic [DATA_W-1:0] w_pdata;
    logic [31:0]       w_n_clamp, w_off, w_addr32;
    logic [2:0]        w_occ;

    assign w_trig    = f_cmp(rdy) && !f_cmp(r_rdy_q);
    assign w_n_clamp = (size_data > c_MAX) ? c_MAX : size_data;
    assign w_bank    = (r_w >= c_DEPTH);
    assign w_off     = w_bank ? (r_w - c_DEPTH) : r_w;
    assign w_addr32  = {w_off[29:0], 2'b00};

    assign m_axis.tdata  = r_d0;
    assign m_axis.tvalid = (r_cnt != 2'd0);
    assign m_axis.tlast  = r_l0;
    assign w_pop         = (r_cnt != 2'd0) && m_axis.tready;
    assign done          = (r_state == ST_DONE);

    // Count the beat leaving this cycle so a full pipeline still issues every cycle.
    assign w_occ   = {1'b0, r_cnt} + {2'b00, r_infl} - {2'b00, w_pop};
    assign w_space = (w_occ < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_issue    = 1'b0;
        w_hdr_push = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trig) begin
                    if (w_n_clamp == 32'd0) w_next = ST_DONE;
`ifdef BRAM_RD_HEADER_EN
                    else                    w_next = ST_HDR;
`else
                    else                    w_next = ST_READ;
`endif
                end
            end
`ifdef BRAM_RD_HEADER_EN
            ST_HDR: begin
                w_hdr_push = 1'b1;
                w_next     = ST_READ;
            end
`endif
            ST_READ: begin
                if (w_space) begin
                    w_issue = 1'b1;
                    if (r_w == r_n - 32'd1) w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_infl && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop)))
                    w_next = ST_DONE;
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        en_a_rd   = w_issue && !w_bank;
        en_b_rd   = w_issue && w_bank;
        bram_addr = w_issue ? ADDR_W'(w_addr32) : '0;
    end

    always_comb begin
        w_push   = r_infl || w_hdr_push;
        w_pdata  = r_infl_b ? dout_b : dout_a;
        w_plast  = r_infl_last;
        w_plasta = r_infl_lasta;
`ifdef BRAM_RD_HEADER_EN
        if (w_hdr_push) begin
            w_pdata  = DATA_W'({r_rdy_lat, 16'b0, r_n[12:0]});
            w_plast  = 1'b0;
            w_plasta = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_q      <= 3'b011;
            r_n          <= '0;
            r_lasta      <= '0;
            r_w          <= '0;
            rd_busy      <= 2'b00;
            r_infl       <= 1'b0;
            r_infl_b     <= 1'b0;
            r_infl_last  <= 1'b0;
            r_infl_lasta <= 1'b0;
`ifdef BRAM_RD_HEADER_EN
            r_rdy_lat    <= 3'b000;
`endif
        end else begin
            r_rdy_q <= rdy;
            if ((r_state == ST_IDLE) && w_trig) begin
                r_n     <= w_n_clamp;
                r_lasta <= ((w_n_clamp > c_DEPTH) ? c_DEPTH : w_n_clamp) - 32'd1;
                r_w     <= '0;
                rd_busy <= {w_n_clamp > c_DEPTH, w_n_clamp != 32'd0};
`ifdef BRAM_RD_HEADER_EN
                r_rdy_lat <= rdy;
`endif
            end else if (w_pop) begin
                if (r_a0) rd_busy[0] <= 1'b0;
                if (r_l0) rd_busy[1] <= 1'b0;
            end
            r_infl <= w_issue;
            if (w_issue) begin
                r_w          <= r_w + 32'd1;
                r_infl_b     <= w_bank;
                r_infl_last  <= (r_w == r_n - 32'd1);
                r_infl_lasta <= (r_w == r_lasta);
            end
        end
    end

    // Two-entry output buffer; slot 0 is always the head presented on the stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_l0  <= 1'b0;
            r_l1  <= 1'b0;
            r_a0  <= 1'b0;
            r_a1  <= 1'b0;
            r_cnt <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b01: begin
                    r_d0  <= r_d1;
                    r_l0  <= r_l1;
                    r_a0  <= r_a1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_d0 <= w_pdata; r_l0 <= w_plast; r_a0 <= w_plasta;
                    end else begin
                        r_d1 <= w_pdata; r_l1 <= w_plast; r_a1 <= w_plasta;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_d0 <= w_pdata; r_l0 <= w_plast; r_a0 <= w_plasta;
                    end else begin
                        r_d0 <= r_d1; r_l0 <= r_l1; r_a0 <= r_a1;
                        r_d1 <= w_pdata; r_l1 <= w_plast; r_a1 <= w_plasta;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bram_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_rd_stream
// Brief    : Self-checking bench: frame table plus reset-mid-frame sequence,
//            with a queue scoreboard of expected stream beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_rd_stream;
    localparam int DEPTH  = 2048;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        rdy = 3'b000;
    logic [31:0]       size_data = 32'd0;
    logic [1:0]        rd_busy;
    logic [ADDR_W-1:0] bram_addr;
    logic              en_a_rd, en_b_rd, done;
    logic [DATA_W-1:0] dout_a = '0, dout_b = '0;

    bram_rd_stream_if #(.DATA_W(DATA_W)) axis ();

    bram_rd_stream #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .size_data(size_data),
        .rd_busy(rd_busy), .bram_addr(bram_addr), .en_a_rd(en_a_rd), .en_b_rd(en_b_rd),
        .dout_a(dout_a), .dout_b(dout_b), .m_axis(axis.master), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_a [0:DEPTH-1];
    logic [31:0] mem_b [0:DEPTH-1];
    always @(posedge clk) begin
        if (en_a_rd) dout_a <= mem_a[bram_addr[12:2]];
        if (en_b_rd) dout_b <= mem_b[bram_addr[12:2]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; logic last; int idx; } beat_t;
    beat_t sb[$];

    typedef struct { logic [2:0] r; logic [31:0] sz; int mode; int exp_n; logic [1:0] exp_busy; } vec_t;
    vec_t vecs [8];

    int checks = 0, errors = 0;
    int tready_mode = 0;
    bit active = 0;
    logic [1:0] m_busy;
    int m_n, m_alast;
    int hs_cnt, last_hs_cyc, first_v_cyc, done_cyc, done_cnt, stray, trig_cyc;
    bit en_b_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream sink ready pattern: 0 = always, 1 = alternating, 2 = random.
    initial begin
        axis.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (tready_mode)
                1:       axis.tready = ~axis.tready;
                2:       axis.tready = 1'($urandom_range(0, 1));
                default: axis.tready = 1'b1;
            endcase
        end
    end

    bit          prev_stall = 0;
    logic [31:0] prev_d;
    logic        prev_l;
    beat_t       b;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_tvalid", axis.tvalid, 1);
                    chk("stall_tdata", axis.tdata, prev_d);
                    chk("stall_tlast", axis.tlast, prev_l);
                end
                if (active) begin
                    chk("rd_busy", rd_busy, m_busy);
                    if (en_b_rd) en_b_seen = 1;
                    if (axis.tvalid && first_v_cyc < 0) first_v_cyc = cyc;
                    if (done) begin
                        done_cnt++;
                        if (done_cyc < 0) done_cyc = cyc;
                    end
                    if (axis.tvalid && axis.tready) begin
                        hs_cnt++;
                        last_hs_cyc = cyc;
                        if (sb.size() == 0) begin
                            chk("extra_beat", axis.tdata, 64'hdead_beef_dead_beef);
                        end else begin
                            b = sb.pop_front();
                            chk("tdata", axis.tdata, b.data);
                            chk("tlast", axis.tlast, b.last);
                            if (b.idx == m_alast) m_busy[0] = 1'b0;
                            if (b.idx == m_n - 1) m_busy[1] = 1'b0;
                        end
                    end
                end else if (axis.tvalid || done) begin
                    stray++;
                end
                prev_stall = axis.tvalid && !axis.tready;
                prev_d     = axis.tdata;
                prev_l     = axis.tlast;
            end
        end
    end

    task automatic arm(input logic [2:0] r, input int exp_n, input logic [1:0] exp_busy);
        logic [31:0] n32;
        n32 = exp_n;
        trig_cyc = cyc;
        m_n      = exp_n;
        m_alast  = ((exp_n > DEPTH) ? DEPTH : exp_n) - 1;
        m_busy   = exp_busy;
        sb.delete();
`ifdef BRAM_RD_HEADER_EN
        if (exp_n > 0) sb.push_back('{{r, 16'h0, n32[12:0]}, 1'b0, -1});
`endif
        for (int i = 0; i < exp_n; i++)
            sb.push_back('{(i < DEPTH) ? i : (32'h1000 + i - DEPTH), (i == exp_n - 1), i});
        first_v_cyc = -1; done_cyc = -1; done_cnt = 0; hs_cnt = 0; en_b_seen = 0;
        active = 1;
    endtask

    task automatic run_frame(input logic [2:0] r, input logic [31:0] sz, input int mode,
                             input int exp_n, input logic [1:0] exp_busy);
        @(posedge clk); #1;
        rdy = 3'b000;
        tready_mode = mode;
        repeat (2) @(posedge clk);
        #1;
        rdy = r;
        size_data = sz;
        @(posedge clk); #1;
        arm(r, exp_n, exp_busy);
        for (int c = 0; c < 4 * exp_n + 200 && done_cyc < 0; c++) @(posedge clk);
        @(posedge clk); #1;
        active = 0;
        chk("done_seen", done_cyc >= 0, 1);
        chk("done_pulses", done_cnt, 1);
        chk("beats_left", sb.size(), 0);
        chk("beats_count", hs_cnt, exp_n + ((exp_n > 0 && `ifdef BRAM_RD_HEADER_EN 1 `else 0 `endif) ? 1 : 0));
        chk("bank_b_used", en_b_seen, exp_n > DEPTH);
        if (exp_n == 0) begin
            chk("zero_done_lat", done_cyc - trig_cyc, 0);
            chk("zero_no_valid", first_v_cyc, -1);
        end else begin
`ifdef BRAM_RD_HEADER_EN
            chk("first_valid_lat", first_v_cyc - trig_cyc, 1);
`else
            chk("first_valid_lat", first_v_cyc - trig_cyc, 2);
`endif
            chk("done_after_last", done_cyc - last_hs_cyc, 1);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = i;
            mem_b[i] = 32'h1000 + i;
        end
        vecs[0] = '{3'b011, 32'd4096, 0, 4096, 2'b11};
        vecs[1] = '{3'b101, 32'd5,    0, 5,    2'b01};
        vecs[2] = '{3'b011, 32'd8,    1, 8,    2'b01};
        vecs[3] = '{3'b011, 32'd0,    0, 0,    2'b00};
        vecs[4] = '{3'b011, 32'd5000, 0, 4096, 2'b11};
        vecs[5] = '{3'b011, 32'd2049, 2, 2049, 2'b11};
        vecs[6] = '{3'b101, 32'd2048, 2, 2048, 2'b01};
        vecs[7] = '{3'b011, 32'd1,    1, 1,    2'b01};

        #1;
        chk("rst_rd_busy", rd_busy, 0);
        chk("rst_tvalid", axis.tvalid, 0);
        chk("rst_done", done, 0);
        chk("rst_en_a", en_a_rd, 0);
        chk("rst_addr", bram_addr, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int v = 0; v < 8; v++)
            run_frame(vecs[v].r, vecs[v].sz, vecs[v].mode, vecs[v].exp_n, vecs[v].exp_busy);

        // Reset partway through a frame with the complete status still held.
        @(posedge clk); #1;
        rdy = 3'b000; tready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rdy = 3'b011; size_data = 32'd4096;
        @(posedge clk); #1;
        arm(3'b011, 4096, 2'b11);
        for (int c = 0; c < 400 && hs_cnt < 100; c++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        active = 0;
        sb.delete();
        chk("midrst_beats_reached", hs_cnt >= 100, 1);
        chk("midrst_rd_busy", rd_busy, 0);
        chk("midrst_addr", bram_addr, 0);
        chk("midrst_en_a", en_a_rd, 0);
        chk("midrst_en_b", en_b_rd, 0);
        chk("midrst_tdata", axis.tdata, 0);
        chk("midrst_tvalid", axis.tvalid, 0);
        chk("midrst_tlast", axis.tlast, 0);
        chk("midrst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        stray = 0;
        repeat (40) @(posedge clk);
        #1;
        chk("no_restart_stray", stray, 0);
        chk("no_restart_busy", rd_busy, 0);
        run_frame(3'b011, 32'd4096, 0, 4096, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
